// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: fetch port, data port and memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        err;
  logic        busy;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  d_req, d_wr, d_addr, d_wdata,
    output d_rdata, d_done, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done,
    output err, busy
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output d_req, d_wr, d_addr, d_wdata,
    input  d_rdata, d_done, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done,
    input  err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the unified 16-bit memory.
// Round-robin on conflicts, alignment fault and timeout abort.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic          rr_q, rr_d;
  logic          wr_q, wr_d;
  logic          fault_q, fault_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_d;

  // State and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      rr_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant, issue, wait-for-done and timeout sequencing
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    rr_d    = rr_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    gnt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // gnt_d=1 selects the data port
          gnt_d = bus.d_req & (~bus.if_req | ~rr_q);
          if (bus.if_req && bus.d_req)
            rr_d = gnt_d;
          own_d   = gnt_d;
          addr_d  = gnt_d ? bus.d_addr : bus.if_addr;
          wr_d    = gnt_d & bus.d_wr;
          wdata_d = gnt_d ? bus.d_wdata : '0;
          rdata_d = '0;
          cnt_d   = '0;
          fault_d = addr_d[0];
          state_d = addr_d[0] ? DONE : ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (bus.mem_done) begin
          rdata_d = wr_q ? 16'h0000 : bus.mem_rdata;
          fault_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TMAX) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic act;
  logic fin;

  assign act = (state_q == ISSUE) || (state_q == WAIT);
  assign fin = (state_q == DONE);

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_wr    = act & wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_done  = fin & ~own_q;
  assign bus.d_done   = fin & own_q;
  assign bus.if_rdata = bus.if_done ? rdata_q : 16'h0000;
  assign bus.d_rdata  = bus.d_done ? rdata_q : 16'h0000;
  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.d_stall  = bus.d_req & ~bus.d_done;
  assign bus.err      = fin & fault_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8).
// Inputs change and outputs are checked on the falling edge.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_done  = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_in();
    rst = 1'b1;
    #1;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_d_done", bus.d_done, 0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_if_rdata", bus.if_rdata, 16'h0000);
    chk("rst_d_rdata", bus.d_rdata, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // fetch alone, mem_done two cycles after mem_en
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    tick();
    chk("f1_mem_en", bus.mem_en, 1);
    chk("f1_mem_addr", bus.mem_addr, 16'h0010);
    chk("f1_mem_wr", bus.mem_wr, 0);
    chk("f1_if_done_c1", bus.if_done, 0);
    chk("f1_stall_c1", bus.if_stall, 1);
    tick();
    chk("f1_mem_en_c2", bus.mem_en, 0);
    chk("f1_if_done_c2", bus.if_done, 0);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'hABCD;
    chk("f1_if_done_c3", bus.if_done, 0);
    tick();
    bus.mem_done = 1'b0;
    chk("f1_if_done", bus.if_done, 1);
    chk("f1_if_rdata", bus.if_rdata, 16'hABCD);
    chk("f1_d_done", bus.d_done, 0);
    chk("f1_err", bus.err, 0);
    chk("f1_stall_done", bus.if_stall, 0);
    bus.if_req = 1'b0;
    tick();
    chk("f1_if_done_c5", bus.if_done, 0);
    chk("f1_busy_c5", bus.busy, 0);

    // conflict after reset: data wins, then fetch wins next conflict
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.d_req = 1'b1;
    bus.d_wr = 1'b1;
    bus.d_addr = 16'h0100;
    bus.d_wdata = 16'h1234;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0002;
    tick();
    chk("c_mem_en", bus.mem_en, 1);
    chk("c_mem_wr", bus.mem_wr, 1);
    chk("c_mem_addr", bus.mem_addr, 16'h0100);
    chk("c_mem_wdata", bus.mem_wdata, 16'h1234);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    tick();
    bus.mem_done = 1'b0;
    chk("c_d_done", bus.d_done, 1);
    chk("c_st_rdata", bus.d_rdata, 16'h0000);
    chk("c_mem_wr_done", bus.mem_wr, 0);
    chk("c_if_done0", bus.if_done, 0);
    chk("c_if_stall", bus.if_stall, 1);
    bus.d_req = 1'b0;
    bus.d_wr = 1'b0;
    tick();
    chk("c_busy_idle", bus.busy, 0);
    tick();
    chk("c_f_mem_en", bus.mem_en, 1);
    chk("c_f_mem_addr", bus.mem_addr, 16'h0002);
    chk("c_f_mem_wr", bus.mem_wr, 0);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_done = 1'b0;
    chk("c_f_done", bus.if_done, 1);
    chk("c_f_rdata", bus.if_rdata, 16'h1111);
    bus.if_req = 1'b0;
    tick();
    bus.d_req = 1'b1;
    bus.d_addr = 16'h0030;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0040;
    tick();
    chk("c2_mem_addr", bus.mem_addr, 16'h0040);
    chk("c2_mem_wr", bus.mem_wr, 0);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h2222;
    tick();
    bus.mem_done = 1'b0;
    chk("c2_if_done", bus.if_done, 1);
    chk("c2_if_rdata", bus.if_rdata, 16'h2222);
    chk("c2_d_done", bus.d_done, 0);
    chk("c2_d_stall", bus.d_stall, 1);
    bus.if_req = 1'b0;
    tick();
    tick();
    chk("c2_d_addr", bus.mem_addr, 16'h0030);
    chk("c2_d_mem_en", bus.mem_en, 1);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h3333;
    tick();
    bus.mem_done = 1'b0;
    chk("c2_d_done1", bus.d_done, 1);
    chk("c2_d_rdata", bus.d_rdata, 16'h3333);
    bus.d_req = 1'b0;
    tick();

    // unaligned load
    bus.d_req = 1'b1;
    bus.d_addr = 16'h0003;
    tick();
    chk("u_mem_en", bus.mem_en, 0);
    chk("u_d_done", bus.d_done, 1);
    chk("u_err", bus.err, 1);
    chk("u_d_rdata", bus.d_rdata, 16'h0000);
    bus.d_req = 1'b0;
    tick();
    chk("u_busy", bus.busy, 0);
    chk("u_err_off", bus.err, 0);

    // fetch timeout, mem_done never returned
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0004;
    tick();
    chk("t_mem_en", bus.mem_en, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("t_if_done_c%0d", i), bus.if_done, 0);
    end
    tick();
    chk("t_if_done", bus.if_done, 1);
    chk("t_err", bus.err, 1);
    chk("t_if_rdata", bus.if_rdata, 16'h0000);
    bus.if_req = 1'b0;
    tick();
    chk("t_busy", bus.busy, 0);

    // mem_done in the issue cycle, stray mem_done in DONE and IDLE
    bus.d_req = 1'b1;
    bus.d_addr = 16'h0020;
    tick();
    chk("z_mem_en", bus.mem_en, 1);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h5A5A;
    tick();
    chk("z_d_done", bus.d_done, 1);
    chk("z_d_rdata", bus.d_rdata, 16'h5A5A);
    bus.d_req = 1'b0;
    tick();
    chk("z_stray_busy", bus.busy, 0);
    chk("z_stray_done", bus.d_done, 0);
    tick();
    bus.mem_done = 1'b0;
    chk("z_idle_busy", bus.busy, 0);

    // reset while a store waits
    bus.d_req = 1'b1;
    bus.d_wr = 1'b1;
    bus.d_addr = 16'h0050;
    bus.d_wdata = 16'h9999;
    tick();
    tick();
    chk("r_busy_wait", bus.busy, 1);
    chk("r_wr_wait", bus.mem_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_mem_en", bus.mem_en, 0);
    chk("r_mem_wr", bus.mem_wr, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_d_done", bus.d_done, 0);
    chk("r_err", bus.err, 0);
    bus.d_req = 1'b0;
    bus.d_wr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("r_no_done", bus.d_done, 0);
    bus.if_req = 1'b1;
    bus.if_addr = 16'h000A;
    tick();
    chk("r_f_mem_en", bus.mem_en, 1);
    chk("r_f_addr", bus.mem_addr, 16'h000A);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_done = 1'b0;
    chk("r_f_done", bus.if_done, 1);
    chk("r_f_err", bus.err, 0);
    chk("r_f_rdata", bus.if_rdata, 16'h7777);
    bus.if_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
